// File: rtl/mem_defs.sv
// Shared width codes, FSM encodings and request payload for the data memory responder.
package mem_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned F3_W_ = 3;

  localparam logic [F3_W_-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request fields captured on the accept edge
  typedef struct packed {
    logic             write;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [F3_W_-1:0] funct3;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half/word lane steering for loads and stores on a 32-bit word.
module mem_lane_align
  import mem_defs::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic        write_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_word_o,
  output logic [3:0]  byte_we_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] wrep;

  // Pick the addressed byte and half out of the stored word
  always_comb begin
    sel_byte = old_word_i[7:0];
    unique case (off_i)
      2'd0: sel_byte = old_word_i[7:0];
      2'd1: sel_byte = old_word_i[15:8];
      2'd2: sel_byte = old_word_i[23:16];
      2'd3: sel_byte = old_word_i[31:24];
      default: sel_byte = old_word_i[7:0];
    endcase
    sel_half = off_i[1] ? old_word_i[31:16] : old_word_i[15:0];
  end

  // Width decode: load extension, store lane enables, alignment and legality
  always_comb begin
    load_data_o  = '0;
    byte_we_o    = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    wrep         = wdata_i;
    case (funct3_i)
      F3_B: begin
        load_data_o = {{24{sel_byte[7]}}, sel_byte};
        byte_we_o   = 4'b0001 << off_i;
        wrep        = {4{wdata_i[7:0]}};
      end
      F3_BU: begin
        load_data_o = {24'd0, sel_byte};
        illegal_o   = write_i;
      end
      F3_H: begin
        load_data_o  = {{16{sel_half[15]}}, sel_half};
        misaligned_o = off_i[0];
        byte_we_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wrep         = {2{wdata_i[15:0]}};
      end
      F3_HU: begin
        load_data_o  = {16'd0, sel_half};
        misaligned_o = off_i[0];
        illegal_o    = write_i;
      end
      F3_W: begin
        load_data_o  = old_word_i;
        misaligned_o = (off_i != 2'd0);
        byte_we_o    = 4'b1111;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Merge replicated store data into the enabled lanes, keep the rest
  always_comb begin
    merged_word_o = old_word_i;
    for (int i = 0; i < 4; i++) begin
      if (byte_we_o[i]) merged_word_o[8*i +: 8] = wrep[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data memory target: accept, wait, commit the access, hold the response.
module data_mem_responder
  import mem_defs::*;
#(
  parameter int unsigned MEMSIZE     = 4096,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW    = $clog2(MEMSIZE);
  localparam int unsigned CNT_W = 4;

  state_e           state_q, state_d;
  mem_req_t         cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_error_q, rsp_error_d;

  logic [31:0]      mem [MEMSIZE];

  logic [31:0]      off;
  logic [AW-1:0]    idx;
  logic             out_of_range;
  logic [31:0]      old_word;
  logic [31:0]      merged_word;
  logic [3:0]       byte_we;
  logic [31:0]      load_data;
  logic             misaligned;
  logic             illegal;
  logic             acc_err;
  logic             accept;
  logic             commit;
  logic             commit_we;

  assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign commit = (state_q == ST_WAIT) && (cnt_q == '0);

  // Address translation from the captured request
  always_comb begin
    off          = cap_q.addr - ADDR_BASE;
    idx          = off[AW+1:2];
    out_of_range = |off[31:AW+2];
  end

  assign old_word = mem[idx];

  mem_lane_align u_align (
    .funct3_i      (cap_q.funct3),
    .off_i         (off[1:0]),
    .write_i       (cap_q.write),
    .old_word_i    (old_word),
    .wdata_i       (cap_q.wdata),
    .merged_word_o (merged_word),
    .byte_we_o     (byte_we),
    .load_data_o   (load_data),
    .misaligned_o  (misaligned),
    .illegal_o     (illegal)
  );

  assign acc_err   = misaligned | illegal | out_of_range;
  assign commit_we = commit && cap_q.write && !acc_err && (byte_we != 4'b0000);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)          state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0)     state_d = ST_RESP;
      ST_RESP: if (rsp_ready)       state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; WAIT always lasts WAIT_STATES+1 cycles so the
  // access commits on the edge that enters RESP, WAIT_STATES+1 edges after accept
  always_comb begin
    cap_d       = cap_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    req_ready_d = (state_d == ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cap_d.write  = req_write;
          cap_d.addr   = req_addr;
          cap_d.wdata  = req_wdata;
          cap_d.funct3 = req_funct3;
          cnt_d        = CNT_W'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_valid_d = 1'b1;
          rsp_error_d = acc_err;
          rsp_rdata_d = (acc_err || cap_q.write) ? 32'd0 : load_data;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_error_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and capture state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Word array store port; contents survive reset
  always_ff @(posedge clk) begin
    if (commit_we) mem[idx] <= merged_word;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
